// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with address match, byte receive and byte transmit
// Define I2C_SLAVE_GLITCH_FILTER_EN for a 3-sample majority filter on sclk/sda_in.
module i2c_slave #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] data_in,
    output logic       tx_load,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT_STOP
    } state_t;

    state_t                 st, st_n;
    logic [SYNC_STAGES-1:0] scl_s, sda_s;
    logic                   scl, sda, scl_q, sda_q;
    logic                   scl_rise, scl_fall, start, stop, addr_hit;
    logic [2:0]             cnt, cnt_n;
    logic [7:0]             sh, sh_n, dout_n;
    logic                   ack, ack_n, sda_n, rxv_n, rw_n, busy_n;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            scl_s <= '1;
            sda_s <= '1;
        end else begin
            scl_s <= {scl_s[SYNC_STAGES-2:0], sclk};
            sda_s <= {sda_s[SYNC_STAGES-2:0], sda_in};
        end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] scl_f, sda_f;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            scl_f <= '1;
            sda_f <= '1;
        end else begin
            scl_f <= {scl_f[1:0], scl_s[SYNC_STAGES-1]};
            sda_f <= {sda_f[1:0], sda_s[SYNC_STAGES-1]};
        end
    assign scl = (scl_f[0] & scl_f[1]) | (scl_f[1] & scl_f[2]) | (scl_f[0] & scl_f[2]);
    assign sda = (sda_f[0] & sda_f[1]) | (sda_f[1] & sda_f[2]) | (sda_f[0] & sda_f[2]);
`else
    assign scl = scl_s[SYNC_STAGES-1];
    assign sda = sda_s[SYNC_STAGES-1];
`endif

    // START/STOP need sclk high on both samples, so they can never coincide with an sclk edge
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;
    assign addr_hit = sh[6:0] == ADDR;
    assign state    = st;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st       <= S_IDLE;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            cnt      <= '0;
            sh       <= '0;
            ack      <= 1'b0;
            sda_out  <= 1'b1;
            data_out <= '0;
            rx_valid <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
        end else begin
            st       <= st_n;
            scl_q    <= scl;
            sda_q    <= sda;
            cnt      <= cnt_n;
            sh       <= sh_n;
            ack      <= ack_n;
            sda_out  <= sda_n;
            data_out <= dout_n;
            rx_valid <= rxv_n;
            rw       <= rw_n;
            busy     <= busy_n;
        end

    // ack marks the second half of an ACK slot (driven in ADDR_ACK/RX_ACK, master ACK seen in TX_ACK)
    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        sh_n    = sh;
        ack_n   = ack;
        sda_n   = sda_out;
        dout_n  = data_out;
        rxv_n   = 1'b0;
        rw_n    = rw;
        busy_n  = busy;
        tx_load = 1'b0;
        if (start) begin
            st_n  = S_ADDR;
            cnt_n = '0;
            ack_n = 1'b0;
            sda_n = 1'b1;
        end else if (stop) begin
            st_n   = S_IDLE;
            cnt_n  = '0;
            ack_n  = 1'b0;
            sda_n  = 1'b1;
            busy_n = 1'b0;
        end else begin
            case (st)
                S_ADDR:
                    if (scl_rise) begin
                        sh_n  = {sh[6:0], sda};
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            st_n   = addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
                            rw_n   = addr_hit ? sda : rw;
                            busy_n = addr_hit;
                            ack_n  = 1'b0;
                        end
                    end
                S_ADDR_ACK, S_RX_ACK:
                    if (scl_fall) begin
                        ack_n = ~ack;
                        if (!ack)
                            sda_n = 1'b0;
                        else if (st == S_ADDR_ACK && rw) begin
                            tx_load = 1'b1;
                            sda_n   = data_in[7];
                            sh_n    = {data_in[6:0], 1'b1};
                            cnt_n   = 3'd1;
                            st_n    = S_TX;
                        end else begin
                            sda_n = 1'b1;
                            cnt_n = '0;
                            st_n  = S_RX;
                        end
                    end
                S_RX:
                    if (scl_rise) begin
                        sh_n  = {sh[6:0], sda};
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            dout_n = {sh[6:0], sda};
                            rxv_n  = 1'b1;
                            ack_n  = 1'b0;
                            st_n   = S_RX_ACK;
                        end
                    end
                S_TX:
                    if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_n = 1'b1;
                            ack_n = 1'b0;
                            st_n  = S_TX_ACK;
                        end else begin
                            sda_n = sh[7];
                            sh_n  = {sh[6:0], 1'b1};
                            cnt_n = cnt + 3'd1;
                        end
                    end
                S_TX_ACK:
                    if (scl_rise) begin
                        st_n   = sda ? S_WAIT_STOP : st;
                        busy_n = sda ? 1'b0 : busy;
                        ack_n  = ~sda;
                    end else if (scl_fall && ack) begin
                        tx_load = 1'b1;
                        sda_n   = data_in[7];
                        sh_n    = {data_in[6:0], 1'b1};
                        cnt_n   = 3'd1;
                        ack_n   = 1'b0;
                        st_n    = S_TX;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: randomized bus-level bench for i2c_slave with a queue-based reference model
// Build with I2C_SLAVE_GLITCH_FILTER_EN to also exercise the glitch filter.
module tb_i2c_slave;
    localparam logic [6:0] SLV = 7'h42;
    localparam int Q = 80;

    logic       clk = 1'b0, rst = 1'b0, sclk = 1'b1, sda_in = 1'b1;
    logic [7:0] data_in = '0;
    logic       sda_out, tx_load, rx_valid, rw, busy;
    logic [7:0] data_out;
    logic [2:0] state;

    int         checks = 0, errors = 0;
    int         rx_cnt = 0, tx_cnt = 0, low_cnt = 0, drop_hi = 0;
    logic       sda_prev = 1'b1;
    logic [7:0] loaded_q[$];
    logic [7:0] exp_dout = '0;

    i2c_slave #(.ADDR(SLV), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .sda_in(sda_in), .sda_out(sda_out),
        .data_in(data_in), .tx_load(tx_load), .data_out(data_out), .rx_valid(rx_valid),
        .rw(rw), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (rx_valid) rx_cnt++;
        if (tx_load) begin
            tx_cnt++;
            loaded_q.push_back(data_in);
        end
        if (!sda_out) low_cnt++;
        if (sda_prev && !sda_out && sclk) drop_hi++;
        sda_prev = sda_out;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not reach its end in time");
        $fatal(1);
    end

    task automatic bit_clk(input logic b, output logic s);
        sda_in = b; #Q;
        sclk = 1'b1; #Q;
        s = sda_out; #Q;
        sclk = 1'b0; #Q;
    endtask

    task automatic do_start;
        sda_in = 1'b1; #Q;
        sclk = 1'b1; #Q;
        sda_in = 1'b0; #Q;
        sclk = 1'b0; #Q;
    endtask

    task automatic do_stop;
        sda_in = 1'b0; #Q;
        sclk = 1'b1; #Q;
        sda_in = 1'b1; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        logic d;
        for (int i = 7; i >= 0; i--) bit_clk(b[i], d);
        bit_clk(1'b1, a);
    endtask

    task automatic recv_bits(output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, d);
            b[i] = d;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda_out); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        checks++; if ({rx_valid, tx_load, rw, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {rx_valid, tx_load, rw, busy}); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        #9;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        logic [7:0] q[$];
        logic       a;
        int         r0, n, l0;
        for (int it = 0; it < 4; it++) begin
            q = {};
            n = (it == 0) ? 1 : $urandom_range(1, 3);
            for (int k = 0; k < n; k++) q.push_back((it == 0) ? 8'hA5 : 8'($urandom));
            r0 = rx_cnt;
            d0_reset_drop();
            do_start;
            send_byte({SLV, 1'b0}, a);
            checks++; if (a !== 1'b0) begin errors++; $display("FAIL write_addr_ack: sda %b want 0", a); end
            checks++; if (busy !== 1'b1 || rw !== 1'b0) begin errors++; $display("FAIL write_busy_rw: got %b%b want 10", busy, rw); end
            for (int k = 0; k < n; k++) begin
                send_byte(q[k], a);
                checks++; if (a !== 1'b0) begin errors++; $display("FAIL write_data_ack: sda %b want 0", a); end
                checks++; if (data_out !== q[k]) begin errors++; $display("FAIL write_data_out: got %h want %h", data_out, q[k]); end
                checks++; if (rx_cnt - r0 !== k + 1) begin errors++; $display("FAIL write_rx_valid: got %0d pulses want %0d", rx_cnt - r0, k + 1); end
            end
            exp_dout = q[n-1];
            l0 = low_cnt;
            do_stop; #Q;
            checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL write_stop: state %0d busy %b want 0 0", state, busy); end
            checks++; if (low_cnt !== l0) begin errors++; $display("FAIL write_release: sda low %0d cycles after last ACK want 0", low_cnt - l0); end
            checks++; if (drop_hi !== 0) begin errors++; $display("FAIL write_sda_timing: %0d drives while sclk high want 0", drop_hi); end
        end
    endtask

    task automatic d0_reset_drop;
        drop_hi = 0;
    endtask

    task automatic test_bad_addr;
        logic [6:0] ad;
        logic       a;
        int         r0, l0;
        for (int it = 0; it < 3; it++) begin
            ad = (it == 0) ? 7'h43 : 7'($urandom);
            if (ad == SLV) ad = ~SLV;
            r0 = rx_cnt;
            l0 = low_cnt;
            do_start;
            send_byte({ad, (it == 0) ? 1'b0 : 1'($urandom)}, a);
            checks++; if (state !== 3'd7) begin errors++; $display("FAIL badaddr_state: got %0d want 7", state); end
            send_byte(8'($urandom), a);
            checks++; if (low_cnt !== l0) begin errors++; $display("FAIL badaddr_sda: low %0d cycles want 0", low_cnt - l0); end
            checks++; if (rx_cnt !== r0 || busy !== 1'b0) begin errors++; $display("FAIL badaddr_rx: rx %0d busy %b want 0 0", rx_cnt - r0, busy); end
            do_stop; #Q;
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL badaddr_stop: got %0d want 0", state); end
            checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL badaddr_dout: got %h want %h", data_out, exp_dout); end
        end
    endtask

    task automatic test_read;
        logic [7:0] q[$];
        logic [7:0] got;
        logic       a, d;
        int         t0, n;
        for (int it = 0; it < 3; it++) begin
            q = {};
            n = (it == 0) ? 2 : $urandom_range(1, 4);
            for (int k = 0; k < n; k++)
                q.push_back((it == 0) ? ((k == 0) ? 8'hF6 : 8'h3C) : 8'($urandom));
            t0 = tx_cnt;
            loaded_q = {};
            d0_reset_drop();
            data_in = q[0];
            do_start;
            send_byte({SLV, 1'b1}, a);
            checks++; if (a !== 1'b0 || rw !== 1'b1) begin errors++; $display("FAIL read_addr: ack %b rw %b want 0 1", a, rw); end
            for (int k = 0; k < n; k++) begin
                recv_bits(got);
                checks++; if (got !== q[k]) begin errors++; $display("FAIL read_bits: got %h want %h", got, q[k]); end
                data_in = (k + 1 < n) ? q[k+1] : 8'($urandom);
                bit_clk(k == n - 1, d);
            end
            #Q;
            checks++; if (state !== 3'd7 || busy !== 1'b0) begin errors++; $display("FAIL read_nack: state %0d busy %b want 7 0", state, busy); end
            checks++; if (tx_cnt - t0 !== n) begin errors++; $display("FAIL read_tx_load: got %0d pulses want %0d", tx_cnt - t0, n); end
            for (int k = 0; k < n && k < loaded_q.size(); k++) begin
                checks++; if (loaded_q[k] !== q[k]) begin errors++; $display("FAIL read_loaded: got %h want %h", loaded_q[k], q[k]); end
            end
            checks++; if (drop_hi !== 0) begin errors++; $display("FAIL read_sda_timing: %0d drives while sclk high want 0", drop_hi); end
            do_stop; #Q;
            checks++; if (state !== 3'd0) begin errors++; $display("FAIL read_stop: got %0d want 0", state); end
        end
    endtask

    task automatic test_stop_mid;
        logic a, d;
        int   r0;
        r0 = rx_cnt;
        do_start;
        send_byte({SLV, 1'b0}, a);
        for (int i = 0; i < 4; i++) bit_clk(1'($urandom), d);
        do_stop; #Q;
        checks++; if (state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL stopmid_state: state %0d busy %b want 0 0", state, busy); end
        checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL stopmid_dout: got %h want %h", data_out, exp_dout); end
        checks++; if (rx_cnt !== r0) begin errors++; $display("FAIL stopmid_rx: got %0d pulses want 0", rx_cnt - r0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b, v, got;
        logic       a, d;
        b = 8'($urandom);
        v = 8'($urandom);
        do_start;
        send_byte({SLV, 1'b0}, a);
        send_byte(b, a);
        exp_dout = b;
        checks++; if (data_out !== b) begin errors++; $display("FAIL rstart_write: got %h want %h", data_out, b); end
        data_in = v;
        do_start;
        send_byte({SLV, 1'b1}, a);
        checks++; if (a !== 1'b0 || rw !== 1'b1) begin errors++; $display("FAIL rstart_addr: ack %b rw %b want 0 1", a, rw); end
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL rstart_tx: state %0d want 5", state); end
        recv_bits(got);
        checks++; if (got !== v) begin errors++; $display("FAIL rstart_read: got %h want %h", got, v); end
        bit_clk(1'b1, d);
        do_stop; #Q;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rstart_stop: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid;
        logic       a, d;
        logic [7:0] b;
        data_in = {1'b0, 7'($urandom)};
        do_start;
        send_byte({SLV, 1'b1}, a);
        checks++; if (sda_out !== 1'b0 || state !== 3'd5) begin errors++; $display("FAIL rstmid_setup: sda %b state %0d want 0 5", sda_out, state); end
        rst = 1'b0;
        #1;
        checks++; if (sda_out !== 1'b1) begin errors++; $display("FAIL rstmid_sda: got %b want 1", sda_out); end
        checks++; if ({data_out, rx_valid, tx_load, rw, busy, state} !== 15'd0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", {data_out, rx_valid, tx_load, rw, busy, state}); end
        exp_dout = '0;
        #(Q - 1);
        sda_in = 1'b1;
        sclk = 1'b1;
        #(4 * Q);
        rst = 1'b1;
        #Q;
        sclk = 1'b0; #Q;
        send_byte({SLV, 1'b0}, a);
        checks++; if (a !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL rstmid_nostart: ack %b state %0d want 1 0", a, state); end
        b = 8'($urandom);
        do_start;
        send_byte({SLV, 1'b0}, a);
        send_byte(b, d);
        checks++; if (a !== 1'b0 || d !== 1'b0 || data_out !== b) begin errors++; $display("FAIL rstmid_recover: ack %b%b data %h want 00 %h", a, d, data_out, b); end
        exp_dout = b;
        do_stop; #Q;
    endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    task automatic test_glitch;
        int bad;
        bad = 0;
        sda_in = 1'b0; #10;
        sda_in = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (state !== 3'd0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_start: %0d non-idle cycles want 0", bad); end
        sclk = 1'b1;
        sda_in = 1'b0; #10;
        sda_in = 1'b1; #10;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (state !== 3'd0 || busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL glitch_repeat: %0d non-idle cycles want 0", bad); end
    endtask
`endif

    initial begin
        test_reset;
        test_write;
        test_bad_addr;
        test_read;
        test_stop_mid;
        test_back_to_back;
        test_reset_mid;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        test_glitch;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
